// File: rtl/pwm_dac.sv
// PWM output stage: double-buffers a fixed-point sample and emits a 2**SAMPLE_BITS-cycle PWM period.
// Optional first-order error-feedback dither on the truncated fraction when PWM_DAC_DITHER_EN is defined.
module pwm_dac #(
  parameter int SAMPLE_BITS = 7,
  parameter int FRAC_BITS   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [SAMPLE_BITS+FRAC_BITS-1:0] s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic                           pwm,
  output logic                           frame_start,
  output logic                           underrun
);

  localparam int W = SAMPLE_BITS + FRAC_BITS;

  logic [SAMPLE_BITS-1:0] cnt;
  logic [SAMPLE_BITS-1:0] act;
  logic [SAMPLE_BITS-1:0] next_code;
  logic [W-1:0]           pend;
  logic                   pend_full;
  logic                   boundary;

  assign boundary = &cnt;
  assign s_ready  = !pend_full;
  assign pwm      = (cnt < act);

`ifdef PWM_DAC_DITHER_EN
  logic [FRAC_BITS-1:0] err;
  logic [FRAC_BITS-1:0] next_err;
  logic [W:0]           sum;

  // Carry the discarded fraction into the next sample; saturate rather than wrap.
  always_comb begin
    sum       = {1'b0, pend} + {{(SAMPLE_BITS + 1){1'b0}}, err};
    next_code = sum[W-1:FRAC_BITS];
    next_err  = sum[FRAC_BITS-1:0];
    if (sum[W]) begin
      next_code = '1;
      next_err  = '0;
    end
  end
`else
  logic unused_frac;

  assign next_code   = pend[W-1:FRAC_BITS];
  assign unused_frac = ^pend[FRAC_BITS-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      act         <= '0;
      pend        <= '0;
      pend_full   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
`ifdef PWM_DAC_DITHER_EN
      err         <= '0;
`endif
    end else begin
      cnt         <= cnt + 1'b1;
      frame_start <= boundary;
      underrun    <= boundary && !pend_full;
      if (boundary && pend_full) begin
        act       <= next_code;
        pend_full <= 1'b0;
`ifdef PWM_DAC_DITHER_EN
        err       <= next_err;
`endif
      end else if (s_valid && s_ready) begin
        pend      <= s_data;
        pend_full <= 1'b1;
      end
    end
  end

endmodule
